// File: rtl/pwm_multi_pkg.sv
// Shared encodings for the multi-channel PWM block: register selects and CTRL bit positions.
package pwm_multi_pkg;

  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_PHASE  = 2'd2,
    SEL_CTRL   = 2'd3
  } cfg_sel_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

endpackage

// File: rtl/pwm_multi_chan.sv
// One PWM channel: double-buffered period/duty/phase/ctrl, free-running counter, registered output.
// Phase support is built only when PWM_MULTI_PHASE_EN is defined.
module pwm_multi_chan
  import pwm_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] data,
  input  logic             sync,
  output logic             pwm_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] per_p, duty_p, per_a, duty_a, cnt;
  logic [1:0]       ctrl_p;
  logic             en_a, inv_a;

  logic [CNT_W-1:0] per_n, duty_n, ph_n, start_val;
  logic [1:0]       ctrl_n;
  logic             at_wrap, xfer;

  function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] ph,
                                                   input logic [CNT_W-1:0] per);
    return (ph > per) ? '0 : ph;
  endfunction

`ifdef PWM_MULTI_PHASE_EN
  logic [CNT_W-1:0] ph_p, ph_a;
`endif

  // Pending values with this cycle's write folded in, so a write on a transfer edge is not lost.
  always_comb begin
    per_n  = (wr && sel == SEL_PERIOD) ? data : per_p;
    duty_n = (wr && sel == SEL_DUTY)   ? data : duty_p;
    ctrl_n = (wr && sel == SEL_CTRL)   ? data[CTRL_INV:CTRL_EN] : ctrl_p;
`ifdef PWM_MULTI_PHASE_EN
    ph_n   = (wr && sel == SEL_PHASE)  ? data : ph_p;
`else
    ph_n   = '0;
`endif
    at_wrap   = en_a && (cnt == per_a);
    xfer      = !en_a || at_wrap || sync;
    start_val = clamp_phase(ph_n, per_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_p  <= '0;
      duty_p <= '0;
      ctrl_p <= '0;
      per_a  <= '0;
      duty_a <= '0;
      en_a   <= 1'b0;
      inv_a  <= 1'b0;
      cnt    <= '0;
      pwm_o  <= 1'b0;
      wrap_o <= 1'b0;
`ifdef PWM_MULTI_PHASE_EN
      ph_p   <= '0;
      ph_a   <= '0;
`endif
    end else begin
      per_p  <= per_n;
      duty_p <= duty_n;
      ctrl_p <= ctrl_n;
`ifdef PWM_MULTI_PHASE_EN
      ph_p   <= ph_n;
      if (xfer) ph_a <= ph_n;
`endif
      if (xfer) begin
        per_a  <= per_n;
        duty_a <= duty_n;
        en_a   <= ctrl_n[CTRL_EN];
        inv_a  <= ctrl_n[CTRL_INV];
      end
      // Start (disabled -> enabled) and sync both reload the phase; sync outranks wrap.
      if (!en_a || sync)
        cnt <= ctrl_n[CTRL_EN] ? start_val : '0;
      else if (at_wrap)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      pwm_o  <= en_a ? ((cnt < duty_a) ^ inv_a) : inv_a;
      wrap_o <= at_wrap;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// NUM_CH-channel PWM generator: decodes the register-write port into per-channel strobes.
// Define PWM_MULTI_PHASE_EN to build per-channel phase offsets.
module pwm_multi_ch
  import pwm_multi_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              sync,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] wrap_o
);

  logic [NUM_CH-1:0] ch_wr;

  // Indices at or above NUM_CH match no channel, so such writes fall away.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_wr[gi] = cfg_wr && (cfg_ch == CH_W'(gi));

    pwm_multi_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .wr     (ch_wr[gi]),
      .sel    (cfg_sel),
      .data   (cfg_data),
      .sync   (sync),
      .pwm_o  (pwm_o[gi]),
      .wrap_o (wrap_o[gi])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (NUM_CH=8, CNT_W=16, CH_W=4); outputs sampled 1 ns after each rising edge.
module tb_pwm_multi_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        sync;
  logic [7:0]  pwm_o;
  logic [7:0]  wrap_o;

  int n_chk = 0;
  int n_bad = 0;

  localparam int PER = 0, DUT = 1, PHS = 2, CTL = 3;

  pwm_multi_ch #(.NUM_CH(8), .CNT_W(16), .CH_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .sync     (sync),
    .pwm_o    (pwm_o),
    .wrap_o   (wrap_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int ch, input int sel, input int data);
    cfg_wr   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = 16'(data);
    tick(1);
    cfg_wr   = 1'b0;
  endtask

  logic [19:0] p0, w0;
  logic [69:0] p1, w1;
  logic [11:0] c4, c5, c6, w7, c0;
  logic [15:0] c2, c3;
  logic [15:0] exp_ph;

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; sync = 1'b0;
    tick(3);
    chk("reset_pwm", 64'(pwm_o), 64'h0);
    chk("reset_wrap", 64'(wrap_o), 64'h0);
    rst = 1'b0;
    tick(1);

    // Basic duty on ch0: 3 high / 7 low, wrap every 10
    cfg(0, PER, 9);
    cfg(0, DUT, 3);
    cfg(0, CTL, 1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      p0[k] = pwm_o[0];
      w0[k] = wrap_o[0];
    end
    chk("basic_pwm", 64'(p0), 64'h01C07);
    chk("basic_wrap", 64'(w0), 64'h80200);

    // Double buffering on ch1, then disable with INV mid-period
    cfg(1, PER, 19);
    cfg(1, DUT, 5);
    cfg(1, CTL, 1);
    for (int k = 0; k < 70; k++) begin
      if (k == 8)  begin cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_sel = 2'(DUT); cfg_data = 16'd15; end
      if (k == 45) begin cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_sel = 2'(CTL); cfg_data = 16'd2; end
      tick(1);
      cfg_wr = 1'b0;
      p1[k] = pwm_o[1];
      w1[k] = wrap_o[1];
    end
    chk("dbuf_pwm", 64'(p1[39:0]), 64'h07FFF0001F);
    chk("dbuf_wrap", 64'(w1[39:0]), 64'h8000080000);
    chk("disable_pwm", 64'(p1[69:40]), 64'h3FF07FFF);
    chk("disable_wrap", 64'(w1[69:40]), 64'h80000);

    // Edge duties: D0, D>P, INV with D0, PERIOD=0
    cfg(4, PER, 9);  cfg(4, DUT, 0);  cfg(4, CTL, 1);
    cfg(5, PER, 9);  cfg(5, DUT, 10); cfg(5, CTL, 1);
    cfg(6, PER, 9);  cfg(6, DUT, 0);  cfg(6, CTL, 3);
    cfg(7, PER, 0);  cfg(7, CTL, 1);
    tick(2);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      c4[k] = pwm_o[4];
      c5[k] = pwm_o[5];
      c6[k] = pwm_o[6];
      w7[k] = wrap_o[7];
    end
    chk("duty0", 64'(c4), 64'h000);
    chk("duty_gt_per", 64'(c5), 64'hFFF);
    chk("inv_duty0", 64'(c6), 64'hFFF);
    chk("per0_wrap", 64'(w7), 64'hFFF);

    // Phase offset and sync on ch2/ch3
    cfg(2, PER, 7); cfg(2, DUT, 4);
    cfg(3, PER, 7); cfg(3, DUT, 4); cfg(3, PHS, 4);
    cfg(2, CTL, 1); cfg(3, CTL, 1);
    tick(3);
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      c2[k] = pwm_o[2];
      c3[k] = pwm_o[3];
    end
`ifdef PWM_MULTI_PHASE_EN
    exp_ph = 16'hF0F0;
`else
    exp_ph = 16'h0F0F;
`endif
    chk("sync_ch2", 64'(c2), 64'h0F0F);
    chk("sync_ch3_phase", 64'(c3), 64'(exp_ph));

    // PHASE=12 written in the sync cycle: write-through, clamped to 0
    cfg_wr = 1'b1; cfg_ch = 4'd3; cfg_sel = 2'(PHS); cfg_data = 16'd12; sync = 1'b1;
    tick(1);
    cfg_wr = 1'b0; sync = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      c2[k] = pwm_o[2];
      c3[k] = pwm_o[3];
    end
    chk("clamp_ch2", 64'(c2), 64'h0F0F);
    chk("clamp_ch3", 64'(c3), 64'h0F0F);

    // Reset mid-period drops pending writes; out-of-range channel ignored
    cfg(0, DUT, 7);
    chk("pre_rst_inv_ch6", 64'(pwm_o[6]), 64'h1);
    rst = 1'b1;
    tick(1);
    chk("rst_pwm", 64'(pwm_o), 64'h0);
    chk("rst_wrap", 64'(wrap_o), 64'h0);
    rst = 1'b0;
    cfg(0, PER, 9);
    cfg(0, CTL, 1);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      c0[k] = pwm_o[0];
    end
    chk("rst_lost_duty", 64'(c0), 64'h000);
    cfg(9, CTL, 3);
    cfg(9, DUT, 5);
    tick(2);
    chk("ch9_ignored", 64'(pwm_o), 64'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
